// File: rtl/radix4_input_deserializer.sv
// rtl/radix4_input_deserializer.sv - serial-to-parallel front end of a radix-4 SDF FFT stage
// Buffers the first 3/4 of each frame and emits {x[k], x[d+k], x[2d+k], x[3d+k]} during the last quarter.
module radix4_input_deserializer #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32,
    localparam int D    = DEPTH / 4,
    localparam int IW   = (D > 1) ? $clog2(D) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             in_first,
    input  logic [WIDTH-1:0] in_real,
    input  logic [WIDTH-1:0] in_imag,
    output logic             out_valid,
    output logic [IW-1:0]    out_index,
    output logic [WIDTH-1:0] out_real_0,
    output logic [WIDTH-1:0] out_real_1,
    output logic [WIDTH-1:0] out_real_2,
    output logic [WIDTH-1:0] out_real_3,
    output logic [WIDTH-1:0] out_imag_0,
    output logic [WIDTH-1:0] out_imag_1,
    output logic [WIDTH-1:0] out_imag_2,
    output logic [WIDTH-1:0] out_imag_3,
    output logic             frame_error
);

    localparam int PW = $clog2(DEPTH);
    localparam int SR_LEN = 3 * D;
    localparam logic [PW-1:0] THREE_D = PW'(SR_LEN);

    logic [WIDTH-1:0] sr_re_q [0:SR_LEN-1];
    logic [WIDTH-1:0] sr_im_q [0:SR_LEN-1];
    logic [WIDTH-1:0] out_re_q [0:3];
    logic [WIDTH-1:0] out_im_q [0:3];
    logic [PW-1:0]    phase_q;
    logic [PW-1:0]    phase_d;
    logic [PW-1:0]    eff_phase;
    logic             out_valid_q;
    logic             out_valid_d;
    logic [IW-1:0]    out_index_q;
    logic [IW-1:0]    out_index_d;
    logic             frame_error_q;
    logic             frame_error_d;

    // A flagged first sample forces phase 0 regardless of where the counter was.
    always_comb begin
        eff_phase     = (in_valid && in_first) ? '0 : phase_q;
        phase_d       = phase_q;
        out_valid_d   = 1'b0;
        out_index_d   = out_index_q;
        frame_error_d = frame_error_q;
        if (in_valid) begin
            phase_d = eff_phase + PW'(1);
            if (eff_phase >= THREE_D) begin
                out_valid_d = 1'b1;
                out_index_d = IW'(eff_phase - THREE_D);
            end
            if (in_first && (phase_q != '0)) begin
                frame_error_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            phase_q       <= '0;
            out_valid_q   <= 1'b0;
            out_index_q   <= '0;
            frame_error_q <= 1'b0;
            for (int i = 0; i < SR_LEN; i++) begin
                sr_re_q[i] <= '0;
                sr_im_q[i] <= '0;
            end
            for (int j = 0; j < 4; j++) begin
                out_re_q[j] <= '0;
                out_im_q[j] <= '0;
            end
        end else begin
            phase_q       <= phase_d;
            out_valid_q   <= out_valid_d;
            out_index_q   <= out_index_d;
            frame_error_q <= frame_error_d;
            if (in_valid) begin
                sr_re_q[0] <= in_real;
                sr_im_q[0] <= in_imag;
                for (int i = 1; i < SR_LEN; i++) begin
                    sr_re_q[i] <= sr_re_q[i-1];
                    sr_im_q[i] <= sr_im_q[i-1];
                end
            end
            // Taps read pre-shift contents, so they line up with the sample now arriving.
            if (out_valid_d) begin
                out_re_q[0] <= sr_re_q[3*D-1];
                out_im_q[0] <= sr_im_q[3*D-1];
                out_re_q[1] <= sr_re_q[2*D-1];
                out_im_q[1] <= sr_im_q[2*D-1];
                out_re_q[2] <= sr_re_q[D-1];
                out_im_q[2] <= sr_im_q[D-1];
                out_re_q[3] <= in_real;
                out_im_q[3] <= in_imag;
            end
        end
    end

    assign out_valid   = out_valid_q;
    assign out_index   = out_index_q;
    assign frame_error = frame_error_q;
    assign out_real_0  = out_re_q[0];
    assign out_real_1  = out_re_q[1];
    assign out_real_2  = out_re_q[2];
    assign out_real_3  = out_re_q[3];
    assign out_imag_0  = out_im_q[0];
    assign out_imag_1  = out_im_q[1];
    assign out_imag_2  = out_im_q[2];
    assign out_imag_3  = out_im_q[3];

endmodule

// File: tb/tb_radix4_input_deserializer.sv
// tb/tb_radix4_input_deserializer.sv - directed self-checking bench for radix4_input_deserializer
module tb_radix4_input_deserializer;

    localparam int DEPTH = 16;
    localparam int W     = 32;

    logic          clock = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_first;
    logic [W-1:0]  in_real;
    logic [W-1:0]  in_imag;
    logic          out_valid;
    logic [1:0]    out_index;
    logic [W-1:0]  out_real_0, out_real_1, out_real_2, out_real_3;
    logic [W-1:0]  out_imag_0, out_imag_1, out_imag_2, out_imag_3;
    logic          frame_error;

    int vectors = 0;
    int miscompares = 0;
    logic [W-1:0] last_re3;

    radix4_input_deserializer #(.DEPTH(DEPTH), .WIDTH(W)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_first(in_first),
        .in_real(in_real), .in_imag(in_imag), .out_valid(out_valid), .out_index(out_index),
        .out_real_0(out_real_0), .out_real_1(out_real_1), .out_real_2(out_real_2), .out_real_3(out_real_3),
        .out_imag_0(out_imag_0), .out_imag_1(out_imag_1), .out_imag_2(out_imag_2), .out_imag_3(out_imag_3),
        .frame_error(frame_error)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, then sample 1 time unit after the edge.
    task automatic step(input logic v, input logic f, input logic [W-1:0] re, input logic [W-1:0] im);
        reset    = 1'b0;
        in_valid = v;
        in_first = f;
        in_real  = re;
        in_imag  = im;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        in_first = 1'b0;
        in_real  = '0;
        in_imag  = '0;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, W'(out_valid), '0);
        chk({tag, "_index"}, W'(out_index), '0);
        chk({tag, "_re0"}, out_real_0, '0);
        chk({tag, "_re3"}, out_real_3, '0);
        chk({tag, "_im0"}, out_imag_0, '0);
        chk({tag, "_im3"}, out_imag_3, '0);
        chk({tag, "_ferr"}, W'(frame_error), '0);
    endtask

    // Tuple k of a frame whose x[0] has real value base: x[j*4+k] = base + 4j + k, imag negated.
    task automatic chk_tuple(input string tag, input int base, input int k);
        int v0, v1, v2, v3;
        v0 = base + k; v1 = base + 4 + k; v2 = base + 8 + k; v3 = base + 12 + k;
        chk({tag, "_valid"}, W'(out_valid), 1);
        chk({tag, "_index"}, W'(out_index), W'(k));
        chk({tag, "_re0"}, out_real_0, W'(v0));
        chk({tag, "_re1"}, out_real_1, W'(v1));
        chk({tag, "_re2"}, out_real_2, W'(v2));
        chk({tag, "_re3"}, out_real_3, W'(v3));
        chk({tag, "_im0"}, out_imag_0, W'(-v0));
        chk({tag, "_im1"}, out_imag_1, W'(-v1));
        chk({tag, "_im2"}, out_imag_2, W'(-v2));
        chk({tag, "_im3"}, out_imag_3, W'(-v3));
    endtask

    task automatic send(input int n, input logic f);
        step(1'b1, f, W'(n), W'(-n));
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_real = '0; in_imag = '0;
        repeat (3) @(posedge clock);
        #1;
        do_reset();
        chk_zero("reset");

        // Test 1 and 2: two back-to-back frames n=0..31.
        for (int n = 0; n < 32; n++) begin
            send(n, (n % 16) == 0);
            if ((n % 16) >= 12) chk_tuple("stream", (n / 16) * 16, (n % 16) - 12);
            else chk("stream_idle", W'(out_valid), 0);
        end
        chk("stream_ferr", W'(frame_error), 0);

        // Test 3: random stalls; outputs hold while stalled.
        do_reset();
        last_re3 = '0;
        for (int n = 0; n < 16; n++) begin
            int gaps;
            gaps = int'($urandom_range(0, 2));
            for (int g = 0; g < gaps; g++) begin
                step(1'b0, 1'b0, 32'hdead_beef, 32'hdead_beef);
                chk("stall_valid", W'(out_valid), 0);
                chk("stall_hold", out_real_3, last_re3);
            end
            send(n, n == 0);
            if (n >= 12) begin
                chk_tuple("gappy", 0, n - 12);
                last_re3 = W'(n);
            end else begin
                chk("gappy_idle", W'(out_valid), 0);
            end
        end
        step(1'b0, 1'b0, '0, '0);
        chk("gappy_after_valid", W'(out_valid), 0);
        chk("gappy_after_hold", out_real_0, W'(3));

        // Test 4: misplaced in_first at n=5 realigns and sets the sticky error.
        do_reset();
        for (int n = 0; n < 5; n++) send(n, n == 0);
        chk("ferr_before", W'(frame_error), 0);
        send(5, 1'b1);
        chk("ferr_set", W'(frame_error), 1);
        chk("ferr_no_tuple", W'(out_valid), 0);
        for (int n = 6; n <= 20; n++) begin
            send(n, 1'b0);
            if (n >= 17) chk_tuple("realign", 5, n - 17);
            else chk("realign_idle", W'(out_valid), 0);
        end
        chk("ferr_sticky", W'(frame_error), 1);

        // Test 5: reset mid-frame after n=13, restart at n=100 without in_first.
        do_reset();
        for (int n = 0; n <= 13; n++) send(n, n == 0);
        chk("pre_reset_re3", out_real_3, W'(13));
        do_reset();
        chk_zero("midreset");
        for (int n = 100; n < 116; n++) begin
            send(n, 1'b0);
            if (n >= 112) chk_tuple("restart", 100, n - 112);
            else chk("restart_idle", W'(out_valid), 0);
        end

        // Test 6: full-scale values pass through bit-exact.
        do_reset();
        for (int n = 0; n < 16; n++) begin
            step(1'b1, n == 0, {W{1'b1}}, '0);
            if (n >= 12) begin
                chk("max_valid", W'(out_valid), 1);
                chk("max_re0", out_real_0, {W{1'b1}});
                chk("max_re1", out_real_1, {W{1'b1}});
                chk("max_re2", out_real_2, {W{1'b1}});
                chk("max_re3", out_real_3, {W{1'b1}});
                chk("max_im0", out_imag_0, '0);
                chk("max_im3", out_imag_3, '0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
